// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD up/down counter with parallel load, wrap/saturate
// boundary handling, a registered terminal-count pulse and a sticky bad-load flag.
module bcd_counter_n #(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_syn,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   Din,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d;
    logic         tc_q, tc_d;
    logic         err_q, err_d;

    logic [W-1:0] inc_val, dec_val;
    logic         at_max, at_min, din_valid;

    always_comb begin : digit_scan
        at_max    = 1'b1;
        at_min    = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q_q[4*i +: 4] != 4'd9) at_max = 1'b0;
            if (q_q[4*i +: 4] != 4'd0) at_min = 1'b0;
            if (Din[4*i +: 4] > 4'd9)  din_valid = 1'b0;
        end
    end

    // Carry/borrow ripple digit by digit; each digit stays a 4-bit 0..9 value.
    always_comb begin : ripple
        logic carry;
        logic borrow;
        carry   = 1'b1;
        borrow  = 1'b1;
        inc_val = q_q;
        dec_val = q_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (q_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (q_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // The ripple already wraps MAX->MIN and MIN->MAX, so saturation just holds.
    always_comb begin : next_state
        q_d   = q_q;
        tc_d  = 1'b0;
        err_d = err_q;
        if (load) begin
            if (din_valid) q_d = Din;
            else           err_d = 1'b1;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    tc_d = 1'b1;
                    q_d  = WRAP ? inc_val : q_q;
                end else begin
                    q_d  = inc_val;
                end
            end else begin
                if (at_min) begin
                    tc_d = 1'b1;
                    q_d  = WRAP ? dec_val : q_q;
                end else begin
                    q_d  = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_syn) begin
        if (!rst_syn) begin
            q_q   <= '0;
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tc_q  <= tc_d;
            err_q <= err_d;
        end
    end

    assign Q   = q_q;
    assign tc  = tc_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n: wrap, saturate and 4-digit instances
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_bcd_counter_n;

    logic clk = 1'b0;
    logic rst_syn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DIGITS=2, WRAP=1
    logic        en_a = 0, up_a = 0, load_a = 0;
    logic [7:0]  din_a = '0, q_a;
    logic        tc_a, err_a;
    // Instance B: DIGITS=2, WRAP=0
    logic        en_b = 0, up_b = 0, load_b = 0;
    logic [7:0]  din_b = '0, q_b;
    logic        tc_b, err_b;
    // Instance C: DIGITS=4, WRAP=1
    logic        en_c = 0, up_c = 0, load_c = 0;
    logic [15:0] din_c = '0, q_c;
    logic        tc_c, err_c;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst_syn(rst_syn), .en(en_a), .up_dn(up_a), .load(load_a),
        .Din(din_a), .Q(q_a), .tc(tc_a), .err(err_a));
    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst_syn(rst_syn), .en(en_b), .up_dn(up_b), .load(load_b),
        .Din(din_b), .Q(q_b), .tc(tc_b), .err(err_b));
    bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) dut_c (
        .clk(clk), .rst_syn(rst_syn), .en(en_c), .up_dn(up_c), .load(load_c),
        .Din(din_c), .Q(q_c), .tc(tc_c), .err(err_c));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd2(input int n);
        logic [7:0] r;
        r[7:4] = 4'((n / 10) % 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic reset_all();
        @(negedge clk);
        {en_a, up_a, load_a} = '0; din_a = '0;
        {en_b, up_b, load_b} = '0; din_b = '0;
        {en_c, up_c, load_c} = '0; din_c = '0;
        rst_syn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_syn = 1'b1;
    endtask

    task automatic step_a(input logic l, input logic e, input logic u, input logic [7:0] d);
        @(negedge clk);
        load_a = l; en_a = e; up_a = u; din_a = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic l, input logic e, input logic u, input logic [7:0] d);
        @(negedge clk);
        load_b = l; en_b = e; up_b = u; din_b = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_c(input logic l, input logic e, input logic u, input logic [15:0] d);
        @(negedge clk);
        load_c = l; en_c = e; up_c = u; din_c = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       load;
        logic       en;
        logic       up_dn;
        logic [7:0] din;
        logic [7:0] exp_q;
        logic       exp_tc;
        logic       exp_err;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // load en up din       q      tc    err
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h47, 8'h47, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h46, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h45, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h3A, 8'h45, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h12, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h13, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h13, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h99, 8'h99, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 8'h09, 8'h09, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0, 1'b1};

        // Reset state, checked while reset is held
        #12;
        check("reset_q_a", 32'(q_a), 32'h00);
        check("reset_tc_a", 32'(tc_a), 32'h0);
        check("reset_err_a", 32'(err_a), 32'h0);
        check("reset_q_b", 32'(q_b), 32'h00);
        check("reset_q_c", 32'(q_c), 32'h0000);
        check("reset_err_c", 32'(err_c), 32'h0);

        // Table-driven vectors on the wrapping counter
        reset_all();
        for (int i = 0; i < 18; i++) begin
            step_a(vecs[i].load, vecs[i].en, vecs[i].up_dn, vecs[i].din);
            check($sformatf("vec%0d_q", i), 32'(q_a), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(vecs[i].exp_tc));
            check($sformatf("vec%0d_err", i), 32'(err_a), 32'(vecs[i].exp_err));
        end

        // Full up-count cycle 01..99,00 with a single tc pulse
        reset_all();
        for (int i = 0; i < 100; i++) begin
            step_a(1'b0, 1'b1, 1'b1, 8'h00);
            check($sformatf("up100_q%0d", i), 32'(q_a), 32'(to_bcd2((i + 1) % 100)));
            check($sformatf("up100_tc%0d", i), 32'(tc_a), 32'(i == 99));
        end

        // Load with en high, then count down across a tens borrow
        step_a(1'b1, 1'b1, 1'b1, 8'h47);
        check("load47_q", 32'(q_a), 32'h47);
        for (int i = 0; i < 8; i++) begin
            step_a(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("down47_q%0d", i), 32'(q_a), 32'(to_bcd2(46 - i)));
        end

        // Saturating counter at both boundaries
        step_b(1'b1, 1'b0, 1'b0, 8'h98);
        check("sat_load98", 32'(q_b), 32'h98);
        for (int i = 0; i < 3; i++) begin
            step_b(1'b0, 1'b1, 1'b1, 8'h00);
            check($sformatf("sat_up_q%0d", i), 32'(q_b), 32'h99);
            check($sformatf("sat_up_tc%0d", i), 32'(tc_b), 32'(i != 0));
        end
        step_b(1'b1, 1'b0, 1'b0, 8'h01);
        check("sat_load01_tc", 32'(tc_b), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step_b(1'b0, 1'b1, 1'b0, 8'h00);
            check($sformatf("sat_dn_q%0d", i), 32'(q_b), 32'h00);
            check($sformatf("sat_dn_tc%0d", i), 32'(tc_b), 32'(i != 0));
        end
        step_b(1'b0, 1'b0, 1'b0, 8'h00);
        check("sat_idle_tc", 32'(tc_b), 32'h0);
        check("sat_err", 32'(err_b), 32'h0);

        // Four-digit ripple carry/borrow and wrap
        step_c(1'b1, 1'b0, 1'b0, 16'h0999);
        check("c_load0999", 32'(q_c), 32'h0999);
        step_c(1'b0, 1'b1, 1'b1, 16'h0000);
        check("c_up_1000", 32'(q_c), 32'h1000);
        check("c_up_tc", 32'(tc_c), 32'h0);
        step_c(1'b0, 1'b1, 1'b0, 16'h0000);
        check("c_dn_0999", 32'(q_c), 32'h0999);
        step_c(1'b1, 1'b0, 1'b0, 16'h9999);
        step_c(1'b0, 1'b1, 1'b1, 16'h0000);
        check("c_wrap_q", 32'(q_c), 32'h0000);
        check("c_wrap_tc", 32'(tc_c), 32'h1);
        step_c(1'b1, 1'b0, 1'b0, 16'h09F9);
        check("c_badload_q", 32'(q_c), 32'h0000);
        check("c_badload_err", 32'(err_c), 32'h1);

        // Asynchronous reset pulse mid-count
        reset_all();
        for (int i = 0; i < 57; i++) step_a(1'b0, 1'b1, 1'b1, 8'h00);
        check("pre_rst_q57", 32'(q_a), 32'h57);
        rst_syn = 1'b0;
        #1;
        check("async_rst_q", 32'(q_a), 32'h00);
        check("async_rst_tc", 32'(tc_a), 32'h0);
        #4;
        rst_syn = 1'b1;
        @(posedge clk); #1;
        check("resume_q01", 32'(q_a), 32'h01);
        @(posedge clk); #1;
        check("resume_q02", 32'(q_a), 32'h02);

        // Reset held across an edge while a load is pending
        @(negedge clk);
        load_a = 1'b1; din_a = 8'h55; en_a = 1'b1; up_a = 1'b1;
        #2;
        rst_syn = 1'b0;
        @(posedge clk); #1;
        check("rst_over_load_q", 32'(q_a), 32'h00);
        #2;
        rst_syn = 1'b1;
        step_a(1'b0, 1'b1, 1'b1, 8'h00);
        check("after_rst_q01", 32'(q_a), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
